branch_address_stack: RTL and testbench
=======================================

// Module: branch_address_stack
// PURPOSE
//   Parametrised LIFO of branch/return instruction addresses (DEPTH x WIDTH), successor to the single
//   branch-address register. Sits beside the program counter: calls push the return address, returns pop it.
//   Keeps the Tick/ClockEnable gating. Adds multi-entry storage, occupancy, selectable full-stack
//   policy and sticky error flags. Output is a registered top-of-stack with a zeroing select (no tri-state).
// PARAMETERS
//   WIDTH      12  address width in bits
//   DEPTH      8   number of entries; power of two, >=2
//   WRAP       0   full policy: 0 = drop push when full; 1 = overwrite oldest entry (circular)
//   PRESET_VAL all-ones  value loaded into the top entry by Preset
// PORTS
//   Clock       in   1           single clock; all state updates on rising edge
//   Reset       in   1           synchronous, active-high; clears all state
//   ClockEnable in   1           operation qualifier
//   Tick        in   1           operation qualifier; op fires only when ClockEnable & Tick (adv)
//   Push        in   1           push D (when adv)
//   Pop         in   1           pop top (when adv)
//   Preset      in   1           overwrite top with PRESET_VAL (when adv); priority over Push/Pop
//   FlagClear   in   1           clear Overflow/Underflow; not gated by adv
//   Cs          in   1           1 = Q forced to 0; storage unaffected
//   D           in   WIDTH       address to push
//   Q           out  WIDTH       registered top-of-stack (0 when empty)
//   Count       out  clog2(DEPTH)+1  number of valid entries, 0..DEPTH
//   Empty       out  1           Count==0
//   Full        out  1           Count==DEPTH
//   Overflow    out  1           sticky: push attempted while full
//   Underflow   out  1           sticky: pop attempted while empty
// BEHAVIOUR
//   - Reset (sync, highest priority): Count=0, top pointer=0, Q=0, Overflow=0, Underflow=0.
//     Storage contents are don't-care. Reset mid-sequence discards all entries.
//   - No adv: no change, except FlagClear.
//   - Priority when adv: Preset > Push&Pop > Push > Pop.
//   - Preset: if Empty, acts as a push of PRESET_VAL. Otherwise the top entry is replaced; Count unchanged.
//   - Push only, not full: mem[tp]<=D, tp<=tp+1 mod DEPTH, Count+1.
//   - Push only, full, WRAP=0: storage unchanged; Overflow<=1.
//   - Push only, full, WRAP=1: same write and tp advance, so the oldest entry is lost; Count stays DEPTH;
//     Overflow<=1.
//   - Pop only, not empty: tp<=tp-1 mod DEPTH, Count-1.
//   - Pop only, empty: no change; Underflow<=1.
//   - Push&Pop together: if not empty, replace top with D (Count, tp unchanged). If empty, plain push;
//     no Underflow.
//   - Q: registered copy of the new top, updated on the same edge as the operation, so it is visible in
//     the cycle after adv. Q=0 whenever the resulting Count==0. When Cs=1, the output is 0
//     (combinational mask of the Q register).
//   - Flags: FlagClear and a new set in the same cycle -> set wins. Flags have no effect on operation.
//   - Pointer arithmetic: tp is clog2(DEPTH) bits with natural wrap. Count saturates at DEPTH
//     (never exceeds it).
// STRUCTURE
//   - Package branch_stack_pkg: op priority encoding enum (OP_NONE, OP_PRESET, OP_REPLACE, OP_PUSH,
//     OP_POP) and the function computing the count width.
//   - Sub-module branch_stack_mem: DEPTH x WIDTH register array with one synchronous write port
//     (we, waddr, wdata) and one combinational read port.
//   - Top level: op decode, pointer/count/flag registers, Q register.
// TESTING
//   1. Reset, then adv-push 0x011, 0x022, 0x033 -> Count=3, Q=0x033. Pop -> Q=0x022, Count=2.
//   2. WRAP=0, DEPTH=8: push 9 values 1..9 -> Full=1, Overflow=1, Q=8. Pop x8 yields 8..1, then Empty=1, Q=0.
//   3. WRAP=1, DEPTH=8: push 1..10 -> Count=8, Overflow=1. Pop x8 yields 10..3.
//   4. Empty: Pop -> Underflow=1, Count=0. Push&Pop with D=0x0AB -> Count=1, Q=0x0AB, Underflow stays 1.
//      FlagClear -> Underflow=0.
//   5. Tick=0 or ClockEnable=0 with Push=1 for 5 cycles -> no change. Cs=1 -> output 0, internal Q kept.
//      Preset with Count=2 -> Q=0xFFF, Count=2.
//   6. Mid-sequence synchronous Reset with Push asserted in the same cycle -> Count=0, Q=0, flags 0.

Source files
------------

// File: rtl/branch_stack_pkg.sv
// Shared types and helpers for the branch address stack.
package branch_stack_pkg;

    // Operation selected for a cycle, already resolved by priority.
    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PRESET  = 3'd1,
        OP_REPLACE = 3'd2,
        OP_PUSH    = 3'd3,
        OP_POP     = 3'd4
    } op_e;

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/branch_stack_mem.sv
// Register array backing the stack: one synchronous write port, one combinational read port.
module branch_stack_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage write; contents are meaningless until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_address_stack.sv
// LIFO of return addresses with occupancy, full-stack policy, sticky error flags
// and a registered, maskable top-of-stack output.
module branch_address_stack
    import branch_stack_pkg::*;
#(
    parameter int              WIDTH      = 12,
    parameter int              DEPTH      = 8,
    parameter bit              WRAP       = 1'b0,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_clock_enable,
    input  logic                          i_tick,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic                          i_preset,
    input  logic                          i_flag_clear,
    input  logic                          i_cs,
    input  logic [WIDTH-1:0]              i_d,
    output logic [WIDTH-1:0]              o_q,
    output logic [count_width(DEPTH)-1:0] o_count,
    output logic                          o_empty,
    output logic                          o_full,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    r_tp;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_overflow;
    logic             r_underflow;

    op_e              w_op;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [PW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [PW-1:0]    w_tp_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [PW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_q_nxt;

    assign w_empty = (r_count == {CW{1'b0}});
    assign w_full  = (r_count == FULL_CNT);

    // Resolve the qualified request into a single operation by priority.
    always_comb begin
        w_op = OP_NONE;
        if (!(i_clock_enable && i_tick)) begin
            w_op = OP_NONE;
        end else if (i_preset) begin
            w_op = OP_PRESET;
        end else if (i_push && i_pop) begin
            w_op = OP_REPLACE;
        end else if (i_push) begin
            w_op = OP_PUSH;
        end else if (i_pop) begin
            w_op = OP_POP;
        end else begin
            w_op = OP_NONE;
        end
    end

    // Next pointer, count, storage write and flag-set requests for the chosen operation.
    // Preset and replace on an empty stack degrade to a push.
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_tp;
        w_wdata     = i_d;
        w_tp_nxt    = r_tp;
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (w_op)
            OP_PRESET, OP_REPLACE: begin
                w_we    = 1'b1;
                w_wdata = (w_op == OP_PRESET) ? PRESET_VAL : i_d;
                if (w_empty) begin
                    w_waddr     = r_tp;
                    w_tp_nxt    = r_tp + PW'(1'b1);
                    w_count_nxt = r_count + CW'(1'b1);
                end else begin
                    w_waddr = r_tp - PW'(1'b1);
                end
            end
            OP_PUSH: begin
                if (!w_full) begin
                    w_we        = 1'b1;
                    w_tp_nxt    = r_tp + PW'(1'b1);
                    w_count_nxt = r_count + CW'(1'b1);
                end else if (WRAP) begin
                    // Circular overwrite: the oldest slot is the one tp now points at.
                    w_we      = 1'b1;
                    w_tp_nxt  = r_tp + PW'(1'b1);
                    w_ovf_set = 1'b1;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
            OP_POP: begin
                if (!w_empty) begin
                    w_tp_nxt    = r_tp - PW'(1'b1);
                    w_count_nxt = r_count - CW'(1'b1);
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // New top value, bypassing the write made on this same edge.
    assign w_raddr = w_tp_nxt - PW'(1'b1);

    always_comb begin
        w_q_nxt = w_rdata;
        if (w_count_nxt == {CW{1'b0}}) begin
            w_q_nxt = {WIDTH{1'b0}};
        end else if (w_we && (w_waddr == w_raddr)) begin
            w_q_nxt = w_wdata;
        end else begin
            w_q_nxt = w_rdata;
        end
    end

    branch_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clock),
        .i_we    (w_we && !i_reset),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Pointer, occupancy and top-of-stack registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tp    <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            r_q     <= {WIDTH{1'b0}};
        end else begin
            r_tp    <= w_tp_nxt;
            r_count <= w_count_nxt;
            r_q     <= w_q_nxt;
        end
    end

    // Sticky error flags; a new set beats a simultaneous clear.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_set | (r_overflow  & ~i_flag_clear);
            r_underflow <= w_unf_set | (r_underflow & ~i_flag_clear);
        end
    end

    assign o_q         = i_cs ? {WIDTH{1'b0}} : r_q;
    assign o_count     = r_count;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_branch_address_stack.sv
// Self-checking bench: a drop-policy and a wrap-policy instance share stimulus;
// a queue holds the expected stack contents and is popped as the DUT pops.
module tb_branch_address_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic        tk = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        preset = 1'b0;
    logic        fclr = 1'b0;
    logic        cs = 1'b0;
    logic [11:0] d = 12'h000;

    logic [11:0] q, wq;
    logic [3:0]  cnt, wcnt;
    logic        emp, wemp, ful, wful, ovf, wovf, unf, wunf;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] sb[$];
    logic [11:0] exp_v;

    always #5 clk = ~clk;

    branch_address_stack #(.WIDTH(12), .DEPTH(8), .WRAP(1'b0)) dut (
        .i_clock(clk), .i_reset(rst), .i_clock_enable(ce), .i_tick(tk),
        .i_push(push), .i_pop(pop), .i_preset(preset), .i_flag_clear(fclr),
        .i_cs(cs), .i_d(d), .o_q(q), .o_count(cnt), .o_empty(emp),
        .o_full(ful), .o_overflow(ovf), .o_underflow(unf)
    );

    branch_address_stack #(.WIDTH(12), .DEPTH(8), .WRAP(1'b1)) dut_w (
        .i_clock(clk), .i_reset(rst), .i_clock_enable(ce), .i_tick(tk),
        .i_push(push), .i_pop(pop), .i_preset(preset), .i_flag_clear(fclr),
        .i_cs(cs), .i_d(d), .o_q(wq), .o_count(wcnt), .o_empty(wemp),
        .o_full(wful), .o_overflow(wovf), .o_underflow(wunf)
    );

    // One clock with the given controls, then return to idle; outputs sampled 1ns after the edge.
    task automatic cyc(input logic c_ce, input logic c_tk, input logic c_push, input logic c_pop,
                       input logic c_pre, input logic c_fclr, input logic [11:0] c_d);
        ce = c_ce; tk = c_tk; push = c_push; pop = c_pop; preset = c_pre; fclr = c_fclr; d = c_d;
        @(posedge clk); #1;
        ce = 1'b1; tk = 1'b1; push = 1'b0; pop = 1'b0; preset = 1'b0; fclr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (q !== 12'h000) begin n_err++; $display("FAIL reset_q: got %h want 000", q); end
        n_cmp++; if (cnt !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt); end
        n_cmp++; if ({emp, ful, ovf, unf} !== 4'b1000) begin n_err++; $display("FAIL reset_flags: got %b want 1000", {emp, ful, ovf, unf}); end
    endtask

    task automatic test_basic();
        logic [11:0] vals[3];
        vals[0] = 12'h011; vals[1] = 12'h022; vals[2] = 12'h033;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
            sb.push_back(vals[i]);
        end
        n_cmp++; if (cnt !== 4'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", cnt); end
        n_cmp++; if (q !== sb[$]) begin n_err++; $display("FAIL basic_top: got %h want %h", q, sb[$]); end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        void'(sb.pop_back());
        n_cmp++; if (q !== sb[$]) begin n_err++; $display("FAIL basic_pop_q: got %h want %h", q, sb[$]); end
        n_cmp++; if (cnt !== 4'd2) begin n_err++; $display("FAIL basic_pop_count: got %0d want 2", cnt); end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'(i));
            if (sb.size() < 8) sb.push_back(12'(i));
        end
        n_cmp++; if ({ful, ovf} !== 2'b11) begin n_err++; $display("FAIL drop_full_ovf: got %b want 11", {ful, ovf}); end
        n_cmp++; if (q !== 12'h008) begin n_err++; $display("FAIL drop_top: got %h want 008", q); end
        for (int i = 0; i < 8; i++) begin
            exp_v = sb.pop_back();
            n_cmp++; if (q !== exp_v) begin n_err++; $display("FAIL drop_pop_seq: got %h want %h", q, exp_v); end
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        end
        n_cmp++; if ({emp, q} !== {1'b1, 12'h000}) begin n_err++; $display("FAIL drop_empty: got emp=%b q=%h want emp=1 q=000", emp, q); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'(i));
            sb.push_back(12'(i));
            if (sb.size() > 8) void'(sb.pop_front());
        end
        n_cmp++; if (wcnt !== 4'd8) begin n_err++; $display("FAIL wrap_count: got %0d want 8", wcnt); end
        n_cmp++; if (wovf !== 1'b1) begin n_err++; $display("FAIL wrap_ovf: got %b want 1", wovf); end
        for (int i = 0; i < 8; i++) begin
            exp_v = sb.pop_back();
            n_cmp++; if (wq !== exp_v) begin n_err++; $display("FAIL wrap_pop_seq: got %h want %h", wq, exp_v); end
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        end
        n_cmp++; if ({wemp, wq} !== {1'b1, 12'h000}) begin n_err++; $display("FAIL wrap_empty: got emp=%b q=%h want emp=1 q=000", wemp, wq); end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        n_cmp++; if ({unf, cnt} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL unf_set: got unf=%b cnt=%0d want unf=1 cnt=0", unf, cnt); end
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0AB);
        sb.push_back(12'h0AB);
        n_cmp++; if ({cnt, q, unf} !== {4'd1, sb[$], 1'b1}) begin n_err++; $display("FAIL pushpop_empty: got cnt=%0d q=%h unf=%b want cnt=1 q=%h unf=1", cnt, q, unf, sb[$]); end
        // Replace on a non-empty stack: top swapped, count unchanged.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0CD);
        sb[$] = 12'h0CD;
        n_cmp++; if ({cnt, q} !== {4'd1, sb[$]}) begin n_err++; $display("FAIL replace: got cnt=%0d q=%h want cnt=1 q=%h", cnt, q, sb[$]); end
        // Pop on empty with FlagClear in the same cycle: set wins.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
        n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL set_beats_clear: got %b want 1", unf); end
        // FlagClear works without adv.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL flag_clear: got %b want 0", unf); end
    endtask

    task automatic test_gating();
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h100); sb.push_back(12'h100);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h200); sb.push_back(12'h200);
        for (int i = 0; i < 5; i++) begin
            cyc(i[0], ~i[0], 1'b1, 1'b0, 1'b0, 1'b0, 12'h3C3);
            n_cmp++; if ({cnt, q} !== {4'd2, sb[$]}) begin n_err++; $display("FAIL gated_push: got cnt=%0d q=%h want cnt=2 q=%h", cnt, q, sb[$]); end
        end
        cs = 1'b1; #1;
        n_cmp++; if (q !== 12'h000) begin n_err++; $display("FAIL cs_mask: got %h want 000", q); end
        cs = 1'b0; #1;
        n_cmp++; if (q !== sb[$]) begin n_err++; $display("FAIL cs_release: got %h want %h", q, sb[$]); end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h3C3);
        sb[$] = 12'hFFF;
        n_cmp++; if ({cnt, q} !== {4'd2, sb[$]}) begin n_err++; $display("FAIL preset: got cnt=%0d q=%h want cnt=2 q=%h", cnt, q, sb[$]); end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        void'(sb.pop_back());
        n_cmp++; if (q !== sb[$]) begin n_err++; $display("FAIL preset_below: got %h want %h", q, sb[$]); end
        // Preset on an empty stack acts as a push.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        n_cmp++; if ({cnt, q} !== {4'd1, 12'hFFF}) begin n_err++; $display("FAIL preset_empty: got cnt=%0d q=%h want cnt=1 q=fff", cnt, q); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h055);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        rst = 1'b1; push = 1'b1; d = 12'h777;
        @(posedge clk); #1;
        rst = 1'b0; push = 1'b0;
        n_cmp++; if ({cnt, q, ovf, unf, emp} !== {4'd0, 12'h000, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_mid: got cnt=%0d q=%h ovf=%b unf=%b emp=%b want 0 000 0 0 1", cnt, q, ovf, unf, emp);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        n_cmp++; if ({cnt, unf} !== {4'd0, 1'b1}) begin n_err++; $display("FAIL reset_mid_discard: got cnt=%0d unf=%b want 0 1", cnt, unf); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_full_drop();
        test_wrap();
        test_underflow();
        test_gating();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
